// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: one product or quotient bit per clock, results in HI/LO.
// Signed ops run on magnitudes; signs are applied in a single fix-up cycle.
module mult_div_unit #(
    parameter int unsigned SIZE = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [SIZE-1:0] operandA,
    input  logic [SIZE-1:0] operandB,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] hi,
    output logic [SIZE-1:0] lo,
    output logic            divZero
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StFix  = 2'd2;

    localparam int unsigned CntW = $clog2(SIZE);
    localparam logic [CntW-1:0] CntLast = CntW'(SIZE - 1);

    logic [1:0]        state_q, state_d;
    logic              is_div_q, is_div_d;
    logic [SIZE-1:0]   opnd_q, opnd_d;
    logic [2*SIZE-1:0] acc_q, acc_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              neg_lo_q, neg_lo_d;
    logic              neg_hi_q, neg_hi_d;
    logic              dz_q, dz_d;
    logic [SIZE-1:0]   hi_q, hi_d;
    logic [SIZE-1:0]   lo_q, lo_d;
    logic              div_zero_q, div_zero_d;
    logic              done_q, done_d;

    logic              sign_a, sign_b;
    logic [SIZE-1:0]   mag_a, mag_b;
    logic [SIZE:0]     prod_sum;
    logic [2*SIZE-1:0] mul_next;
    logic [SIZE:0]     rem_shift, rem_diff;
    logic [2*SIZE-1:0] div_next;
    logic [SIZE-1:0]   rem, quo;

    assign sign_a = operandA[SIZE-1];
    assign sign_b = operandB[SIZE-1];
    assign mag_a  = (op[0] && sign_a) ? -operandA : operandA;
    assign mag_b  = (op[0] && sign_b) ? -operandB : operandB;

    // Multiply: acc holds {partial product, remaining multiplier bits}
    assign prod_sum = {1'b0, acc_q[2*SIZE-1:SIZE]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {prod_sum, acc_q[SIZE-1:1]};

    // Divide: acc holds {partial remainder, dividend bits shifting into quotient}
    assign rem_shift = {acc_q[2*SIZE-1:SIZE], acc_q[SIZE-1]};
    assign rem_diff  = rem_shift - {1'b0, opnd_q};
    assign div_next  = rem_diff[SIZE] ? {rem_shift[SIZE-1:0], acc_q[SIZE-2:0], 1'b0}
                                      : {rem_diff[SIZE-1:0], acc_q[SIZE-2:0], 1'b1};

    assign rem = acc_q[2*SIZE-1:SIZE];
    assign quo = acc_q[SIZE-1:0];

    always_comb begin
        state_d    = state_q;
        is_div_d   = is_div_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        neg_lo_d   = neg_lo_q;
        neg_hi_d   = neg_hi_q;
        dz_d       = dz_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;
        done_d     = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    is_div_d = op[1];
                    cnt_d    = '0;
                    dz_d     = 1'b0;
                    neg_lo_d = op[0] & (sign_a ^ sign_b);
                    neg_hi_d = op[0] & sign_a & op[1];
                    state_d  = StRun;
                    if (op[1]) begin
                        acc_d  = {{SIZE{1'b0}}, mag_a};
                        opnd_d = mag_b;
                        if (operandB == '0) begin
                            // Fix-up passes acc through unchanged: hi = raw dividend, lo = ones
                            acc_d    = {operandA, {SIZE{1'b1}}};
                            neg_lo_d = 1'b0;
                            neg_hi_d = 1'b0;
                            dz_d     = 1'b1;
                            state_d  = StFix;
                        end
                    end else begin
                        acc_d  = {{SIZE{1'b0}}, mag_b};
                        opnd_d = mag_a;
                    end
                end
            end
            StRun: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (is_div_q) begin
                    hi_d = neg_hi_q ? -rem : rem;
                    lo_d = neg_lo_q ? -quo : quo;
                end else begin
                    {hi_d, lo_d} = neg_lo_q ? -acc_q : acc_q;
                end
                div_zero_d = dz_q;
                done_d     = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            is_div_q   <= 1'b0;
            opnd_q     <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            dz_q       <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_div_q   <= is_div_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            neg_lo_q   <= neg_lo_d;
            neg_hi_q   <= neg_hi_d;
            dz_q       <= dz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
            done_q     <= done_d;
        end
    end

    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign divZero = div_zero_q;

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit on the execute side of the datapath. It takes the two register-file read operands and computes either a 2·SIZE-bit product or a quotient/remainder pair into HI/LO result registers, one bit per cycle. Writeback muxes `hi`/`lo` into the register file's write-data path. A start/busy/done handshake lets the control unit stall the pipeline while an operation runs.

## Interface
- `SIZE`, 32, operand and result width in bits; must be ≥ 2.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  operation request; sampled only in IDLE
- `op`  in  2  00 MULTU, 01 MULT (signed), 10 DIVU, 11 DIV (signed)
- `operandA`  in  SIZE  multiplicand / dividend (register-file read data 1)
- `operandB`  in  SIZE  multiplier / divisor (register-file read data 2)
- `busy`  out  1  operation in progress; new starts ignored
- `done`  out  1  one-cycle pulse; `hi`/`lo` valid from this cycle
- `hi`  out  SIZE  product upper half / remainder
- `lo`  out  SIZE  product lower half / quotient
- `divZero`  out  1  last completed op was a divide with `operandB` == 0; held until the next `done`

## Operation
- States: IDLE, RUN, FIX.
- IDLE, `start`=1 at edge E0:
  - latch `op`;
  - latch operand magnitudes (absolute value for signed ops; raw value for unsigned);
  - latch result signs: product sign = signA ^ signB; quotient sign = signA ^ signB; remainder sign = signA;
  - clear iteration counter; go to RUN.
- Divide by zero (`op`[1]=1, `operandB`=0 at E0): go to FIX directly. FIX writes `hi`=`operandA` (raw, unmodified), `lo`=all ones, `divZero`=1.
- RUN, multiply:
  - shift-add on a 2·SIZE-bit accumulator, one multiplier bit per edge;
  - SIZE edges, then go to FIX.
- RUN, divide:
  - restoring division, one quotient bit per edge, using a SIZE+1-bit partial remainder;
  - SIZE edges, then go to FIX.
- FIX (one edge): apply two's-complement negation per the latched signs; write `hi`/`lo`; pulse `done`; update `divZero`; return to IDLE.
- Arithmetic:
  - products are exact 2·SIZE-bit results, so no overflow is possible;
  - signed most-negative ÷ −1 yields quotient = most-negative value, remainder = 0 (natural wrap, no flag);
  - remainder magnitude is always < divisor magnitude.
- `start` while `busy` is ignored, with no queueing. Operand changes during RUN have no effect.
- `hi`/`lo`/`divZero` change only in FIX (or on reset).

## Timing
- Reset (async assert, sync to `clk` on deassert): state IDLE; `busy`=0, `done`=0, `hi`=0, `lo`=0, `divZero`=0; counter and accumulators cleared.
- `busy` = 1 in RUN and FIX; 0 in IDLE.
- Normal latency: start at E0 → `done` high after edge E(SIZE+1), i.e. SIZE+1 edges (33 for SIZE=32).
- Divide-by-zero latency: `done` high after E1.
- `done` is high for exactly one cycle; during that cycle the state is IDLE and `busy`=0.
- Back-to-back: `start` asserted in the `done` cycle is accepted at the next edge. The new result does not disturb the old `hi`/`lo` until its own FIX.
- Reset mid-operation aborts immediately: no `done`; `hi`/`lo` read 0.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001; `done` exactly 33 edges after the start edge; `busy` high for 33 cycles.
- MULT −3 (0xFFFFFFFD) × 5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. MULT 0x80000000 × 0x80000000 → `hi`=0x40000000, `lo`=0.
- DIV −7 ÷ 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 100 ÷ 7 → `lo`=14, `hi`=2. DIV 0x80000000 ÷ 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- DIVU 100 ÷ 0 → `done` after 1 edge, `hi`=0x64, `lo`=0xFFFFFFFF, `divZero`=1. A following MULTU 2×3 clears `divZero` and gives `lo`=6.
- `start` pulsed with different operands mid-RUN → ignored; first result unchanged. A second `start` in the `done` cycle → accepted, second `done` 33 edges later.
- `rst_n` low at edge 10 of a DIVU → `busy`=0, `done` never pulses, `hi`=`lo`=0. After release, a new MULTU 7×6 → `lo`=42.
